sram_1rw1r_arbiter: RTL and testbench

//  Shares the 1RW+1R OpenRAM macro (sky130_sram_1kbyte_1rw1r_32x256_8) between NUM_REQ requesters
//  on port 0 (RW) using round-robin arbitration, and gives one read-only client port 1 (R).

---
 rtl/sram_1rw1r_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_1rw1r_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw1r_arbiter.sv
// sram_1rw1r_arbiter
//   Shares the RW port (port 0) of a 1RW+1R OpenRAM macro among NUM_REQ
//   requesters with round-robin arbitration. It gives the read-only port
//   (port 1) to a single client. Read data returns 2 cycles after the grant:
//   the macro output is valid in T+1 and is registered at the end of T+1.
//   A port-1 read is held off for one cycle when port 0 writes the same
//   address in the same cycle.
// Ports
//   clk, rst                      clock; async active-high reset
//   req/req_we/req_wmask/
//   req_addr/req_wdata            port-0 requests, flat-packed per requester
//   gnt                           one-hot grant, combinational in the request cycle
//   rsp_valid/rsp_data            port-0 read response (one-hot valid)
//   rd_req/rd_addr/rd_gnt         port-1 read request and grant
//   rd_rsp_valid/rd_rsp_data      port-1 read response
//   csb0/web0/wmask0/addr0/din0   macro port-0 pins (active-low selects)
//   dout0                         macro port-0 read data
//   csb1/addr1/dout1              macro port-1 pins
module sram_1rw1r_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*NUM_WMASKS-1:0]    req_wmask,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  input  logic                             rd_req,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic                             rd_gnt,
  output logic                             rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]            rd_rsp_data,
  output logic                             csb0,
  output logic                             web0,
  output logic [NUM_WMASKS-1:0]            wmask0,
  output logic [ADDR_WIDTH-1:0]            addr0,
  output logic [DATA_WIDTH-1:0]            din0,
  input  logic [DATA_WIDTH-1:0]            dout0,
  output logic                             csb1,
  output logic [ADDR_WIDTH-1:0]            addr1,
  input  logic [DATA_WIDTH-1:0]            dout1
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        win_id, idx;
  logic                  win_any;
  logic                  gnt_any;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [NUM_WMASKS-1:0] win_wmask;
  logic                  hazard;

  // Port-0 read pipeline: stage 1 holds {valid,id} while dout0 is live.
  logic                  p0_vld_q;
  logic [IDW-1:0]        p0_id_q;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Port-1 read pipeline.
  logic                  p1_vld_q;
  logic                  rd_rsp_valid_q;
  logic [DATA_WIDTH-1:0] rd_rsp_data_q, rd_rsp_data_d;

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_any && req[idx]) begin
        win_any = 1'b1;
        win_id  = idx;
      end
    end
  end

  // Grants are suppressed while reset is held so pins sit at idle values.
  assign gnt_any   = win_any & ~rst;
  assign win_we    = req_we[win_id];
  assign win_addr  = req_addr[win_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = req_wdata[win_id*DATA_WIDTH +: DATA_WIDTH];
  assign win_wmask = req_wmask[win_id*NUM_WMASKS +: NUM_WMASKS];

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[win_id] = 1'b1;
  end

  assign ptr_d = gnt_any ? win_id : ptr_q;

  // Macro port-0 pins; data and mask are forced to zero on reads.
  assign csb0   = ~gnt_any;
  assign web0   = ~(gnt_any & win_we);
  assign addr0  = gnt_any ? win_addr : '0;
  assign din0   = (gnt_any & win_we) ? win_wdata : '0;
  assign wmask0 = (gnt_any & win_we) ? win_wmask : '0;

  // Same-cycle write to the address port 1 wants would race inside the macro.
  assign hazard = gnt_any & win_we & (win_addr == rd_addr);
  assign rd_gnt = rd_req & ~hazard & ~rst;
  assign csb1   = ~rd_gnt;
  assign addr1  = rd_gnt ? rd_addr : '0;

  always_comb begin
    rsp_valid_d   = '0;
    rsp_data_d    = rsp_data_q;
    rd_rsp_data_d = rd_rsp_data_q;
    if (p0_vld_q) begin
      rsp_valid_d[p0_id_q] = 1'b1;
      rsp_data_d           = dout0;
    end
    if (p1_vld_q) rd_rsp_data_d = dout1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= IDW'(NUM_REQ - 1);
      p0_vld_q       <= 1'b0;
      p0_id_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      p1_vld_q       <= 1'b0;
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_data_q  <= '0;
    end else begin
      ptr_q          <= ptr_d;
      p0_vld_q       <= gnt_any & ~win_we;
      p0_id_q        <= win_id;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      p1_vld_q       <= rd_gnt;
      rd_rsp_valid_q <= p1_vld_q;
      rd_rsp_data_q  <= rd_rsp_data_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rd_rsp_valid = rd_rsp_valid_q;
  assign rd_rsp_data  = rd_rsp_data_q;

endmodule

// File: tb/tb_sram_1rw1r_arbiter.sv
// Directed bench for sram_1rw1r_arbiter with a behavioural 1RW+1R macro:
// the macro latches its pins at posedge and does the write and then the reads at the following negedge.
module tb_sram_1rw1r_arbiter;
  localparam int NR = 2, AW = 8, DW = 32, NM = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req, req_we, gnt, rsp_valid;
  logic [NR*NM-1:0] req_wmask;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_data, rd_rsp_data, din0, dout0, dout1;
  logic             rd_req, rd_gnt, rd_rsp_valid, csb0, web0, csb1;
  logic [AW-1:0]    rd_addr, addr0, addr1;
  logic [NM-1:0]    wmask0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sram_1rw1r_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NM)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_wmask(req_wmask),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .csb0(csb0), .web0(web0),
    .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0), .csb1(csb1),
    .addr1(addr1), .dout1(dout1));

  // Macro model
  logic [DW-1:0] mem [0:255];
  logic          csb0_l = 1'b1, web0_l = 1'b1, csb1_l = 1'b1;
  logic [AW-1:0] addr0_l = '0, addr1_l = '0;
  logic [DW-1:0] din0_l = '0;
  logic [NM-1:0] wmask0_l = '0;
  initial begin dout0 = '0; dout1 = '0; end

  always @(posedge clk) begin
    csb0_l <= csb0; web0_l <= web0; addr0_l <= addr0; din0_l <= din0; wmask0_l <= wmask0;
    csb1_l <= csb1; addr1_l <= addr1;
  end

  always @(negedge clk) begin
    if (!csb0_l && !web0_l)
      for (int b = 0; b < NM; b++)
        if (wmask0_l[b]) mem[addr0_l][8*b +: 8] = din0_l[8*b +: 8];
    if (!csb0_l && web0_l) dout0 = mem[addr0_l];
    if (!csb1_l) dout1 = mem[addr1_l];
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NM-1:0] m);
    req[i] = 1'b1; req_we[i] = we;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d; req_wmask[i*NM +: NM] = m;
  endtask

  task automatic clr_req(input int i);
    req[i] = 1'b0; req_we[i] = 1'b0;
    req_addr[i*AW +: AW] = '0; req_wdata[i*DW +: DW] = '0; req_wmask[i*NM +: NM] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; req_we = '1; req_addr = '1; req_wdata = '1; req_wmask = '1;
    rd_req = 1'b1; rd_addr = 8'h3;
    tick(); tick(); #1;
    n_chk++; if (gnt !== 2'b00) $display("FAIL rst_gnt got %b exp 00", gnt); else n_pass++;
    n_chk++; if (rd_gnt !== 1'b0) $display("FAIL rst_rd_gnt got %b exp 0", rd_gnt); else n_pass++;
    n_chk++; if ({csb0, web0, csb1} !== 3'b111) $display("FAIL rst_csb got %b exp 111", {csb0, web0, csb1}); else n_pass++;
    n_chk++; if ({addr0, addr1, din0, wmask0} !== '0) $display("FAIL rst_pins got %h exp 0", {addr0, addr1, din0, wmask0}); else n_pass++;
    n_chk++; if ({rsp_valid, rd_rsp_valid, rsp_data, rd_rsp_data} !== '0) $display("FAIL rst_rsp got %h exp 0", {rsp_valid, rd_rsp_valid, rsp_data, rd_rsp_data}); else n_pass++;
    // Reset arriving while a read is in flight.
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wmask = '0; rd_req = 1'b0; rd_addr = '0;
    tick(); rst = 1'b0;
    set_req(1, 1'b0, 8'h10, '0, '0);
    #1;
    n_chk++; if (gnt !== 2'b10) $display("FAIL rstmid_gnt got %b exp 10", gnt); else n_pass++;
    tick(); clr_req(1); rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (rsp_valid !== 2'b00 || rsp_data !== '0) $display("FAIL rstmid_rsp c%0d got %b/%h exp 00/0", c, rsp_valid, rsp_data); else n_pass++;
      tick();
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    #1;
    n_chk++; if (gnt !== 2'b01) $display("FAIL wr_gnt got %b exp 01", gnt); else n_pass++;
    n_chk++; if ({csb0, web0, addr0, din0, wmask0} !== {1'b0, 1'b0, 8'h10, 32'hDEADBEEF, 4'hF})
      $display("FAIL wr_pins got %b %b %h %h %h", csb0, web0, addr0, din0, wmask0); else n_pass++;
    tick(); clr_req(0); set_req(1, 1'b0, 8'h10, 32'hFFFF_FFFF, 4'hF);
    #1;
    n_chk++; if (gnt !== 2'b10) $display("FAIL rd_gnt1 got %b exp 10", gnt); else n_pass++;
    n_chk++; if ({csb0, web0, addr0, din0, wmask0} !== {1'b0, 1'b1, 8'h10, 32'h0, 4'h0})
      $display("FAIL rd_pins got %b %b %h %h %h", csb0, web0, addr0, din0, wmask0); else n_pass++;
    tick(); clr_req(1);
    #1;
    n_chk++; if (rsp_valid !== 2'b00) $display("FAIL rd_early got %b exp 00", rsp_valid); else n_pass++;
    tick(); #1;
    n_chk++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hDEADBEEF) $display("FAIL rd_rsp got %b/%h exp 10/deadbeef", rsp_valid, rsp_data); else n_pass++;
    tick(); #1;
    n_chk++; if (rsp_valid !== 2'b00) $display("FAIL rd_pulse got %b exp 00", rsp_valid); else n_pass++;
  endtask

  task automatic test_mask();
    set_req(0, 1'b1, 8'h20, 32'h11223344, 4'hF);
    tick(); set_req(0, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101);
    #1;
    n_chk++; if (wmask0 !== 4'b0101) $display("FAIL mask_pin got %b exp 0101", wmask0); else n_pass++;
    tick(); set_req(0, 1'b0, 8'h20, '0, '0);
    tick(); clr_req(0);
    tick(); #1;
    n_chk++; if (rsp_valid !== 2'b01 || rsp_data !== 32'h11BB33DD) $display("FAIL mask_rsp got %b/%h exp 01/11bb33dd", rsp_valid, rsp_data); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] exp_g [0:5];
    logic [DW-1:0] exp_d [0:5];
    do_reset();
    for (int c = 0; c < 6; c++) begin
      exp_g[c] = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_d[c] = (c % 2 == 0) ? 32'hDEADBEEF : 32'h11BB33DD;
    end
    set_req(0, 1'b0, 8'h10, '0, '0);
    set_req(1, 1'b0, 8'h20, '0, '0);
    for (int c = 0; c < 8; c++) begin
      if (c == 6) begin clr_req(0); clr_req(1); end
      #1;
      if (c < 6) begin
        n_chk++; if (gnt !== exp_g[c]) $display("FAIL rr_gnt c%0d got %b exp %b", c, gnt, exp_g[c]); else n_pass++;
      end else begin
        n_chk++; if (gnt !== 2'b00) $display("FAIL rr_idle c%0d got %b exp 00", c, gnt); else n_pass++;
      end
      if (c >= 2) begin
        n_chk++; if (rsp_valid !== exp_g[c-2] || rsp_data !== exp_d[c-2])
          $display("FAIL rr_rsp c%0d got %b/%h exp %b/%h", c, rsp_valid, rsp_data, exp_g[c-2], exp_d[c-2]); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_hazard();
    set_req(0, 1'b1, 8'h55, 32'hCAFEF00D, 4'hF);
    rd_req = 1'b1; rd_addr = 8'h55;
    #1;
    n_chk++; if (gnt !== 2'b01) $display("FAIL hz_gnt got %b exp 01", gnt); else n_pass++;
    n_chk++; if ({rd_gnt, csb1, addr1} !== {1'b0, 1'b1, 8'h00}) $display("FAIL hz_stall got %b %b %h exp 0 1 00", rd_gnt, csb1, addr1); else n_pass++;
    tick(); clr_req(0);
    #1;
    n_chk++; if ({rd_gnt, csb1, addr1} !== {1'b1, 1'b0, 8'h55}) $display("FAIL hz_retry got %b %b %h exp 1 0 55", rd_gnt, csb1, addr1); else n_pass++;
    tick(); rd_req = 1'b0; rd_addr = '0;
    #1;
    n_chk++; if (rd_rsp_valid !== 1'b0) $display("FAIL hz_early got %b exp 0", rd_rsp_valid); else n_pass++;
    tick(); #1;
    n_chk++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 32'hCAFEF00D) $display("FAIL hz_rsp got %b/%h exp 1/cafef00d", rd_rsp_valid, rd_rsp_data); else n_pass++;
    tick(); #1;
    n_chk++; if (rd_rsp_valid !== 1'b0) $display("FAIL hz_pulse got %b exp 0", rd_rsp_valid); else n_pass++;
  endtask

  task automatic test_no_stall();
    set_req(1, 1'b1, 8'h56, 32'h12345678, 4'hF);
    tick(); clr_req(1);
    set_req(0, 1'b1, 8'h55, 32'h0BADF00D, 4'hF);
    rd_req = 1'b1; rd_addr = 8'h56;
    #1;
    n_chk++; if (gnt !== 2'b01 || rd_gnt !== 1'b1) $display("FAIL ns_gnt got %b/%b exp 01/1", gnt, rd_gnt); else n_pass++;
    tick(); clr_req(0); rd_addr = 8'h55;
    #1;
    n_chk++; if (rd_gnt !== 1'b1 || addr1 !== 8'h55) $display("FAIL raw_gnt got %b/%h exp 1/55", rd_gnt, addr1); else n_pass++;
    tick(); rd_req = 1'b0; rd_addr = '0;
    #1;
    n_chk++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 32'h12345678) $display("FAIL ns_rsp got %b/%h exp 1/12345678", rd_rsp_valid, rd_rsp_data); else n_pass++;
    tick(); #1;
    n_chk++; if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 32'h0BADF00D) $display("FAIL raw_rsp got %b/%h exp 1/0badf00d", rd_rsp_valid, rd_rsp_data); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_mask();
    test_back_to_back();
    test_hazard();
    test_no_stall();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
